// File: rtl/raster_to_block_pkg.sv
// Shared constants and state encodings for the raster-to-block reorder buffer.
// Imported by the top level and its RAM.
package raster_to_block_pkg;

  localparam int BLK_N   = 8;
  localparam int BLK_PIX = 64;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_e;

  typedef enum logic {
    IDLE,
    DRAIN
  } rd_e;

endpackage

// File: rtl/raster_to_block_pingpong_ram.sv
// Two-bank simple dual-port RAM, registered read.
// Bank select is the address MSB.
module pingpong_ram
  import raster_to_block_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/raster_to_block.sv
// Raster-order to 8x8-block-order reorder buffer with ping-pong banks.
// Each full band drains as one gap-free burst into the dct input.
module raster_to_block
  import raster_to_block_pkg::*;
#(
  parameter int IMG_WIDTH = 64,
  parameter int DATA_W    = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [DATA_W-1:0] xout,
  output logic              xout_valid,
  output logic              blk_first,
  output logic              blk_last
);

  localparam int BAND = BLK_N * IMG_WIDTH;
  localparam int AW   = $clog2(BAND);
  localparam int NB   = IMG_WIDTH / BLK_N;
  localparam int CW   = $clog2(IMG_WIDTH);
  localparam int BW   = (NB > 1) ? $clog2(NB) : 1;

  bank_e           bank_q [2];
  bank_e           bank_d [2];
  logic            wb_q, wb_d, rb_q, rb_d;
  logic [2:0]      wr_q, wr_d;
  logic [CW-1:0]   wc_q, wc_d;
  rd_e             st_q, st_d;
  logic [BW-1:0]   b_q, b_d;
  logic [2:0]      r_q, r_d, k_q, k_d;
  logic            vld_q, first_q, last_q;
  logic            xfer, wr_done, issue, rd_last;
  logic [AW-1:0]   woff, roff;
  logic [DATA_W-1:0] rdata;

  assign pix_ready = (bank_q[wb_q] == EMPTY) ||
                     (bank_q[wb_q] == FILLING);
  assign xfer    = pix_valid && pix_ready;
  assign wr_done = xfer && (wr_q == 3'd7) &&
                   (wc_q == CW'(IMG_WIDTH - 1));
  assign rd_last = (k_q == 3'd7) && (r_q == 3'd7) &&
                   (b_q == BW'(NB - 1));

  assign woff = AW'(int'(wr_q) * IMG_WIDTH + int'(wc_q));
  assign roff = AW'(int'(r_q) * IMG_WIDTH +
                    int'(b_q) * BLK_N + int'(k_q));

  always_comb begin
    bank_d = bank_q;
    wb_d   = wb_q;
    rb_d   = rb_q;
    wr_d   = wr_q;
    wc_d   = wc_q;
    st_d   = st_q;
    b_d    = b_q;
    r_d    = r_q;
    k_d    = k_q;
    issue  = 1'b0;

    if (xfer) begin
      bank_d[wb_q] = FILLING;
      if (wc_q == CW'(IMG_WIDTH - 1)) begin
        wc_d = '0;
        wr_d = wr_q + 3'd1;
      end else begin
        wc_d = wc_q + CW'(1);
      end
      if (wr_done) begin
        bank_d[wb_q] = FULL;
        wb_d = ~wb_q;
        wr_d = '0;
      end
    end

    unique case (st_q)
      IDLE: begin
        if (bank_q[rb_q] == FULL) begin
          issue        = 1'b1;
          bank_d[rb_q] = DRAINING;
          st_d         = DRAIN;
        end
      end
      DRAIN: issue = 1'b1;
    endcase

    if (issue) begin
      k_d = k_q + 3'd1;
      if (k_q == 3'd7) begin
        r_d = r_q + 3'd1;
        if (r_q == 3'd7) b_d = b_q + BW'(1);
      end
      if (rd_last) begin
        bank_d[rb_q] = EMPTY;
        rb_d = ~rb_q;
        b_d  = '0;
        r_d  = '0;
        k_d  = '0;
        // A band finishing on this same edge still chains without a bubble
        if (bank_q[~rb_q] == FULL || (wr_done && wb_q != rb_q)) begin
          st_d          = DRAIN;
          bank_d[~rb_q] = DRAINING;
        end else begin
          st_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bank_q[0] <= EMPTY;
      bank_q[1] <= EMPTY;
      wb_q      <= 1'b0;
      rb_q      <= 1'b0;
      wr_q      <= '0;
      wc_q      <= '0;
      st_q      <= IDLE;
      b_q       <= '0;
      r_q       <= '0;
      k_q       <= '0;
      vld_q     <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      bank_q  <= bank_d;
      wb_q    <= wb_d;
      rb_q    <= rb_d;
      wr_q    <= wr_d;
      wc_q    <= wc_d;
      st_q    <= st_d;
      b_q     <= b_d;
      r_q     <= r_d;
      k_q     <= k_d;
      vld_q   <= issue;
      first_q <= issue && (r_q == 3'd0) && (k_q == 3'd0);
      last_q  <= issue && (r_q == 3'd7) && (k_q == 3'd7);
    end
  end

  pingpong_ram #(
    .AW (AW + 1),
    .DW (DATA_W)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (xfer),
    .waddr_i ({wb_q, woff}),
    .wdata_i (pix_in),
    .raddr_i ({rb_q, roff}),
    .rdata_o (rdata)
  );

  assign xout       = vld_q ? rdata : '0;
  assign xout_valid = vld_q;
  assign blk_first  = first_q;
  assign blk_last   = last_q;

endmodule

// File: doc/raster_to_block.md
Name: raster_to_block

Overview:
- Front-end reorder buffer for the DCT/IDCT datapath.
- Accepts image pixels in raster order, one 8-row band at a time, and emits them in 8x8 block order (row-major within each block, blocks left to right) on the 8-bit stream that feeds the dct input xin.
- Ping-pong banking: one band is written while the previous band drains.
- Each band drains as one gap-free burst, because the dct stage consumes a sample every clock.

Parameters:
- IMG_WIDTH, 64: pixels per image row. Must be a multiple of 8 and at least 8.
- DATA_W, 8: pixel width. Must match the dct xin width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- pix_in  in  DATA_W  raster pixel.
- pix_valid  in  1  pix_in is valid.
- pix_ready  out  1  buffer can accept a pixel. A transfer occurs when pix_valid && pix_ready.
- xout  out  DATA_W  block-ordered pixel; drives dct xin.
- xout_valid  out  1  xout holds a valid pixel.
- blk_first  out  1  pulses with pixel 0 of each 8x8 block.
- blk_last  out  1  pulses with pixel 63 of each 8x8 block.

Behaviour:
- Reset values: xout=0, xout_valid=0, blk_first=0, blk_last=0, pix_ready=1. Both banks EMPTY, write bank=0, read bank=0, all counters 0. RAM contents are not cleared.
- Storage: 2 banks of 8*IMG_WIDTH entries. Bank select is the address MSB.
- Bank state cycle: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Write side:
  - Counters row w_r (0..7) and column w_c (0..IMG_WIDTH-1).
  - Write address = w_r*IMG_WIDTH + w_c.
  - Counters advance only on a transfer. w_c wraps to 0 and increments w_r.
  - The transfer at w_r=7, w_c=IMG_WIDTH-1 marks the bank FULL at that clock edge, toggles the write bank, and clears the counters.
- pix_ready = 1 when the current write bank is EMPTY or FILLING, else 0.
- Read-side FSM:
  - States: IDLE, DRAIN.
  - IDLE -> DRAIN when the read bank is FULL; the first read address is issued that cycle.
  - Counters: block b (0..IMG_WIDTH/8-1), row r (0..7), column k (0..7). Read address = r*IMG_WIDTH + b*8 + k.
  - Nesting: k is innermost, then r, then b.
  - One address is issued per cycle, with no gaps, for 8*IMG_WIDTH cycles.
  - On the cycle that issues the final address, the bank becomes EMPTY at that edge and the read bank toggles.
  - At that point the FSM goes to DRAIN again if the other bank is already FULL (back-to-back burst, no bubble), otherwise to IDLE.
- Latency:
  - Synchronous RAM read, registered output.
  - xout/xout_valid appear 1 cycle after the address is issued.
  - First xout_valid is 2 cycles after the transfer that completed the band.
- blk_first is asserted with xout_valid when r=0, k=0. blk_last is asserted with xout_valid when r=7, k=7. Both are aligned to xout.
- When xout_valid=0, xout is held at 0.
- Simultaneous events: a band completing on the write side and the read side freeing a bank in the same cycle both take effect at that edge. Continuous input at 1 pixel/cycle never deasserts pix_ready.
- Gaps in pix_valid: the write pauses and no data is lost. A burst never starts until the bank is complete.
- Reset mid-operation: partial bands are discarded and output stops immediately (outputs return to reset values). Stale RAM data is never emitted, because banks are EMPTY.

Decomposition:
- Shared package: BLK_N=8, BLK_PIX=64, and a bank-state enum (EMPTY, FILLING, FULL, DRAINING).
- One sub-module: pingpong_ram.
  - Simple dual-port RAM: 1 write port, 1 synchronous read port, depth 2*8*IMG_WIDTH, width DATA_W.
  - Infers block RAM.

Test Plan (IMG_WIDTH=16, pixel value = (row*16+col) mod 256):
1. Assert RST for 3 cycles, then idle -> xout=0, xout_valid=0, blk_first=0, blk_last=0, pix_ready=1 throughout.
2. Feed one band (128 pixels, pix_valid held 1, last transfer at cycle T):
   - xout_valid rises at T+2 and stays high 128 cycles.
   - Output order: 0..7, 16..23, ..., 112..119, then 8..15, 24..31, ..., 120..127.
   - blk_first on outputs 0 and 64; blk_last on outputs 63 and 127.
3. Feed 3 bands back-to-back at 1 pixel/cycle -> pix_ready never drops; outputs from bands 1 and 2 form one contiguous 256-cycle burst with no bubble at the bank switch.
4. Feed one band with pix_valid toggling 1/0 -> same 128 values in the same order as scenario 2; xout_valid contiguous, starting 2 cycles after the last accepted pixel.
5. Pulse RST after 50 pixels of a band, then feed a full new band (values +1) -> only the new band's 128 values are output; nothing from the aborted band appears.
6. Pulse RST mid-burst at output 40 -> xout_valid=0 immediately and stays 0 until a new full band completes.
